mips_fetch_stage: RTL

//  Instruction-fetch stage of the pipelined MIPS core (PipelinedProc): owns the PC,

---
 rtl/mips_fetch_stage_pkg.sv | 32 +++
 rtl/mips_fetch_stage_if.sv | 30 +++
 rtl/mips_if_id_reg.sv | 26 ++
 rtl/mips_fetch_stage.sv | 90 +++++++++
 4 files changed

// File: rtl/mips_fetch_stage_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
// The if_id_t record is the IF/ID register image that decode consumes.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  // sll $0,$0,0 -- the canonical MIPS no-op, used to fill bubbles
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc_plus4;
    logic               valid;
  } if_id_t;

  // Builds an empty IF/ID slot carrying the given no-op word
  function automatic if_id_t make_bubble(input logic [INSTR_W-1:0] nop);
    if_id_t b;
    b.instr    = nop;
    b.pc_plus4 = '0;
    b.valid    = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/mips_fetch_stage_if.sv
// Bundle of the fetch stage's control inputs, instruction-memory port
// and IF/ID outputs. master = the fetch stage, slave = its surroundings.
interface mips_fetch_stage_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
);

  logic [PC_W-1:0]  startPC;
  logic             Stall;
  logic             Redirect;
  logic [PC_W-1:0]  RedirectPC;
  logic [PC_W-1:0]  ImemAddr;
  logic [31:0]      ImemData;
  logic [31:0]      IfIdInstr;
  logic [PC_W-1:0]  IfIdPCPlus4;
  logic             IfIdValid;
  logic             FetchFault;
  logic [CNT_W-1:0] FetchCount;

  modport master (
    input  startPC, Stall, Redirect, RedirectPC, ImemData,
    output ImemAddr, IfIdInstr, IfIdPCPlus4, IfIdValid, FetchFault, FetchCount
  );

  modport slave (
    output startPC, Stall, Redirect, RedirectPC, ImemData,
    input  ImemAddr, IfIdInstr, IfIdPCPlus4, IfIdValid, FetchFault, FetchCount
  );

endinterface

// File: rtl/mips_if_id_reg.sv
// IF/ID pipeline register: squash beats load, and with neither asserted
// the register simply holds (that is how a stall freezes it).
module mips_if_id_reg #(
  parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            squash,
  input  mips_pkg::if_id_t d,
  output mips_pkg::if_id_t q
);
  import mips_pkg::*;

  // Capture a fetched word, replace it with a bubble, or keep it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= make_bubble(NOP_WORD);
    end else if (squash) begin
      q <= make_bubble(NOP_WORD);
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mips_fetch_stage.sv
// Instruction-fetch stage: owns the PC and the BOOT/RUN/FAULT sequencing,
// counts delivered instructions, and feeds the IF/ID register.
module mips_fetch_stage #(
  parameter int          PC_W     = 32,
  parameter int          CNT_W    = 32,
  parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
  input logic               CLK,
  input logic               Reset,
  mips_fetch_stage_if.master bus
);
  import mips_pkg::*;

  fetch_state_t     state;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  pc_next_seq;
  logic             fetch_fault;
  logic [CNT_W-1:0] fetch_count;

  logic             running;
  logic             advance;
  logic             redirect_ok;
  logic             redirect_bad;
  logic             squash;
  if_id_t           if_id_d;
  if_id_t           if_id_q;

  // Decode this cycle's action; Redirect outranks Stall, and only RUN acts
  always_comb begin
    running      = (state == RUN);
    pc_next_seq  = pc + PC_W'(4);
    redirect_ok  = running && bus.Redirect && (bus.RedirectPC[1:0] == 2'b00);
    redirect_bad = running && bus.Redirect && (bus.RedirectPC[1:0] != 2'b00);
    advance      = running && !bus.Redirect && !bus.Stall;
    squash       = !running || bus.Redirect;
    if_id_d.instr    = bus.ImemData;
    if_id_d.pc_plus4 = ADDR_W'(pc_next_seq);
    if_id_d.valid    = 1'b1;
  end

  // PC, state machine, sticky fault flag and delivery counter
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state       <= BOOT;
      pc          <= '0;
      fetch_fault <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (state)
        BOOT: begin
          pc    <= bus.startPC;
          state <= RUN;
        end
        RUN: begin
          if (redirect_ok) begin
            pc <= bus.RedirectPC;
          end else if (redirect_bad) begin
            state       <= FAULT;
            fetch_fault <= 1'b1;
          end else if (advance) begin
            pc          <= pc_next_seq;
            fetch_count <= fetch_count + CNT_W'(1);
          end
        end
        default: begin
          state <= FAULT;
        end
      endcase
    end
  end

  mips_if_id_reg #(
    .NOP_WORD(NOP_WORD)
  ) u_if_id (
    .clk   (CLK),
    .rst   (Reset),
    .load  (advance),
    .squash(squash),
    .d     (if_id_d),
    .q     (if_id_q)
  );

  assign bus.ImemAddr    = pc;
  assign bus.IfIdInstr   = if_id_q.instr;
  assign bus.IfIdPCPlus4 = PC_W'(if_id_q.pc_plus4);
  assign bus.IfIdValid   = if_id_q.valid;
  assign bus.FetchFault  = fetch_fault;
  assign bus.FetchCount  = fetch_count;

endmodule
